// File: rtl/sample_stream_sink.sv
// rtl/sample_stream_sink.sv - periodic sample requester and MSB-first serialiser
//
// Once per DIV-cycle period (while en=1) the sink strobes generate_next_sample,
// waits up to TIMEOUT cycles for new_sample_ready, then shifts the 16-bit
// sample out on sdata, MSB first, with sync marking the MSB cycle. If the
// producer misses the window, the previous sample is repeated and the sticky
// underrun flag is raised.
//
// Ports:
//   clk                  - single clock, rising edge
//   reset                - asynchronous, active-low
//   en                   - enables periodic sample requests
//   generate_next_sample - one-cycle request strobe to the producer
//   new_sample_ready     - producer strobe, sample_in valid in the same cycle
//   sample_in[15:0]      - signed sample from the producer
//   clr_underrun         - clears the sticky underrun flag
//   sdata                - serial sample bit, MSB first
//   sync                 - high during the MSB cycle of each frame
//   underrun             - sticky flag: a request timed out
//   sample_count[7:0]    - number of accepted samples (wraps)
//   last_sample[15:0]    - most recently accepted sample

module sample_stream_sink #(
    parameter int DIV     = 32,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        generate_next_sample,
    input  logic        new_sample_ready,
    input  logic [15:0] sample_in,
    input  logic        clr_underrun,
    output logic        sdata,
    output logic        sync,
    output logic        underrun,
    output logic [7:0]  sample_count,
    output logic [15:0] last_sample
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t      state_q;
    logic [PW-1:0] per_q;
    logic [PW-1:0] per_d;
    logic [WW-1:0] wait_q;
    logic [3:0]  bit_q;
    logic [15:0] shift_q;
    logic [15:0] last_q;
    logic [7:0]  count_q;
    logic        underrun_q;
    logic        gen_q;
    logic        sdata_q;
    logic        sync_q;

    logic        accept;
    logic        timeout;
    logic [15:0] frame_word;

    // Period counter free-runs only while enabled so that re-enabling always
    // starts a fresh period with an immediate request.
    always_comb begin
        per_d = per_q;
        if (!en) begin
            per_d = '0;
        end else if (per_q == PW'(DIV - 1)) begin
            per_d = '0;
        end else begin
            per_d = per_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    // Ready is checked before the timeout so a strobe in the final WAIT
    // cycle is still accepted.
    always_comb begin
        accept     = ((state_q == REQ) || (state_q == WAIT)) && new_sample_ready;
        timeout    = (state_q == WAIT) && !new_sample_ready &&
                     (wait_q == WW'(TIMEOUT - 1));
        frame_word = accept ? sample_in : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            last_q     <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            gen_q      <= 1'b0;
            sdata_q    <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            gen_q <= 1'b0;

            // Clear first; a coinciding timeout below overrides it.
            if (clr_underrun) begin
                underrun_q <= 1'b0;
            end

            if (accept || timeout) begin
                // Present the MSB immediately so the first bit appears the
                // cycle after the sample is taken.
                state_q <= SHIFT;
                shift_q <= {frame_word[14:0], 1'b0};
                sdata_q <= frame_word[15];
                sync_q  <= 1'b1;
                bit_q   <= '0;
                if (accept) begin
                    last_q  <= sample_in;
                    count_q <= count_q + 8'd1;
                end else begin
                    underrun_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        sdata_q <= 1'b0;
                        sync_q  <= 1'b0;
                        if (en && (per_q == '0)) begin
                            state_q <= REQ;
                            gen_q   <= 1'b1;
                        end
                    end
                    REQ: begin
                        state_q <= WAIT;
                        wait_q  <= '0;
                    end
                    WAIT: begin
                        wait_q <= wait_q + 1'b1;
                    end
                    SHIFT: begin
                        sync_q <= 1'b0;
                        if (bit_q == 4'd15) begin
                            state_q <= IDLE;
                            sdata_q <= 1'b0;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            sdata_q <= shift_q[15];
                            shift_q <= {shift_q[14:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign generate_next_sample = gen_q;
    assign sdata                = sdata_q;
    assign sync                 = sync_q;
    assign underrun             = underrun_q;
    assign sample_count         = count_q;
    assign last_sample          = last_q;

endmodule

// File: tb/tb_sample_stream_sink.sv
// tb/tb_sample_stream_sink.sv - self-checking bench for sample_stream_sink

module tb_sample_stream_sink;

    localparam int DIV     = 32;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        generate_next_sample;
    logic        new_sample_ready;
    logic [15:0] sample_in;
    logic        clr_underrun;
    logic        sdata;
    logic        sync;
    logic        underrun;
    logic [7:0]  sample_count;
    logic [15:0] last_sample;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: what the sink should hold after each transaction.
    logic [15:0] exp_last;
    logic [7:0]  exp_count;
    logic        exp_under;

    sample_stream_sink #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .en                   (en),
        .generate_next_sample (generate_next_sample),
        .new_sample_ready     (new_sample_ready),
        .sample_in            (sample_in),
        .clr_underrun         (clr_underrun),
        .sdata                (sdata),
        .sync                 (sync),
        .underrun             (underrun),
        .sample_count         (sample_count),
        .last_sample          (last_sample)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Producer answers d cycles after the request strobe (d=0: during the
    // request cycle). d > TIMEOUT means it never answers.
    task automatic model_apply(input int d, input logic [15:0] val, output logic [15:0] ef);
        if (d <= TIMEOUT) begin
            exp_last  = val;
            exp_count = exp_count + 8'd1;
            ef        = val;
        end else begin
            ef        = exp_last;
            exp_under = 1'b1;
        end
    endtask

    task automatic xact(input int d, input logic [15:0] val, input int stray_bit,
                        input bit clr_on_to, input bit en_drop,
                        output logic [15:0] frame, output bit sync_ok,
                        output int gen_cyc, output bit got);
        bit accept;
        int nwait;
        got     = 1'b0;
        frame   = '0;
        sync_ok = 1'b1;
        gen_cyc = 0;
        for (int i = 0; i < 3 * DIV && !got; i++) begin
            @(posedge clk); #1;
            if (generate_next_sample) got = 1'b1;
        end
        if (!got) return;
        gen_cyc = cyc;
        if (en_drop) en = 1'b0;
        accept = (d <= TIMEOUT);
        nwait  = accept ? d : TIMEOUT;
        for (int i = 0; i <= nwait; i++) begin
            new_sample_ready = accept && (i == d);
            sample_in        = new_sample_ready ? val : 16'($urandom);
            clr_underrun     = clr_on_to && !accept && (i == nwait);
            @(posedge clk); #1;
            if (i < nwait && (sync || sdata)) sync_ok = 1'b0;
        end
        new_sample_ready = 1'b0;
        clr_underrun     = 1'b0;
        for (int b = 15; b >= 0; b--) begin
            frame[b] = sdata;
            if (sync !== (b == 15)) sync_ok = 1'b0;
            new_sample_ready = (stray_bit == b);
            sample_in        = new_sample_ready ? 16'hFFFF : 16'($urandom);
            @(posedge clk); #1;
        end
        new_sample_ready = 1'b0;
        if (sdata !== 1'b0 || sync !== 1'b0) sync_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; new_sample_ready = 1'b0;
        sample_in = '0; clr_underrun = 1'b0;
        exp_last = '0; exp_count = '0; exp_under = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({generate_next_sample, sdata, sync, underrun} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {generate_next_sample, sdata, sync, underrun});
        end
        checks++;
        if (sample_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", sample_count);
        end
        checks++;
        if (last_sample !== 16'h0) begin
            errors++; $display("FAIL reset_last got %h exp 0000", last_sample);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [15:0] fr, ef; bit sok, got; int gc;
        en = 1'b1;
        xact(2, 16'hA5C3, -1, 0, 0, fr, sok, gc, got);
        model_apply(2, 16'hA5C3, ef);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_req no request seen"); end
        checks++;
        if (fr !== 16'hA5C3 || !sok) begin
            errors++; $display("FAIL basic_frame got %h sync_ok %0d exp a5c3 1", fr, sok);
        end
        checks++;
        if (last_sample !== 16'hA5C3) begin
            errors++; $display("FAIL basic_last got %h exp a5c3", last_sample);
        end
        checks++;
        if (sample_count !== 8'd1) begin
            errors++; $display("FAIL basic_count got %0d exp 1", sample_count);
        end
    endtask

    task automatic test_period;
        logic [15:0] fr, ef, v; bit sok, got; int gc; int t[4]; int d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 3);
            v = 16'($urandom);
            xact(d, v, -1, 0, 0, fr, sok, gc, got);
            model_apply(d, v, ef);
            t[i] = gc;
            checks++;
            if (!got || fr !== ef || !sok) begin
                errors++; $display("FAIL period_frame%0d got %h sync_ok %0d exp %h", i, fr, sok, ef);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] !== DIV) begin
                errors++; $display("FAIL period_gap%0d got %0d exp %0d", i, t[i] - t[i-1], DIV);
            end
        end
        checks++;
        if (sample_count !== exp_count) begin
            errors++; $display("FAIL period_count got %0d exp %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_timeout;
        logic [15:0] fr, ef; bit sok, got; int gc; logic [7:0] cnt_before;
        xact(1, 16'h1234, -1, 0, 0, fr, sok, gc, got);
        model_apply(1, 16'h1234, ef);
        cnt_before = exp_count;
        xact(TIMEOUT + 1, 16'h0, -1, 0, 0, fr, sok, gc, got);
        model_apply(TIMEOUT + 1, 16'h0, ef);
        checks++;
        if (!got || fr !== 16'h1234 || !sok) begin
            errors++; $display("FAIL timeout_frame got %h sync_ok %0d exp 1234 1", fr, sok);
        end
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL timeout_underrun got %b exp 1", underrun);
        end
        checks++;
        if (sample_count !== cnt_before) begin
            errors++; $display("FAIL timeout_count got %0d exp %0d", sample_count, cnt_before);
        end
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        exp_under = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL timeout_clear got %b exp 0", underrun);
        end
    endtask

    task automatic test_stray;
        logic [15:0] fr, ef, v; bit sok, got; int gc; int sb;
        v  = 16'h6C1E;
        sb = $urandom_range(1, 14);
        xact(0, v, sb, 0, 0, fr, sok, gc, got);
        model_apply(0, v, ef);
        checks++;
        if (!got || fr !== v || !sok) begin
            errors++; $display("FAIL stray_frame got %h sync_ok %0d exp %h 1", fr, sok, v);
        end
        checks++;
        if (last_sample !== v) begin
            errors++; $display("FAIL stray_last got %h exp %h", last_sample, v);
        end
        checks++;
        if (sample_count !== exp_count) begin
            errors++; $display("FAIL stray_count got %0d exp %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_random;
        logic [15:0] fr, ef, v; bit sok, got; int gc; int d;
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(0, TIMEOUT + 3);
            v = 16'($urandom);
            xact(d, v, -1, 0, 0, fr, sok, gc, got);
            model_apply(d, v, ef);
            checks++;
            if (!got || fr !== ef || !sok) begin
                errors++; $display("FAIL rand_frame%0d d=%0d got %h sync_ok %0d exp %h", i, d, fr, sok, ef);
            end
            checks++;
            if ({underrun, sample_count, last_sample} !== {exp_under, exp_count, exp_last}) begin
                errors++; $display("FAIL rand_state%0d got u=%b c=%0d l=%h exp u=%b c=%0d l=%h",
                                   i, underrun, sample_count, last_sample, exp_under, exp_count, exp_last);
            end
        end
    endtask

    task automatic test_en_off;
        logic [15:0] fr, ef, v; bit sok, got; int gc; int reqs;
        v = 16'h8001;
        xact(3, v, -1, 0, 1, fr, sok, gc, got);
        model_apply(3, v, ef);
        checks++;
        if (!got || fr !== v || !sok) begin
            errors++; $display("FAIL enoff_frame got %h sync_ok %0d exp %h 1", fr, sok, v);
        end
        reqs = 0;
        repeat (3 * DIV) begin
            @(posedge clk); #1;
            if (generate_next_sample) reqs++;
        end
        checks++;
        if (reqs !== 0) begin
            errors++; $display("FAIL enoff_requests got %0d exp 0", reqs);
        end
        en = 1'b1;
    endtask

    task automatic test_wrap_setwins;
        logic [15:0] fr, ef, v; bit sok, got; int gc; int d; int n; int bad;
        n   = (exp_count == 8'd0) ? 256 : 256 - int'(exp_count);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, TIMEOUT);
            v = 16'($urandom);
            xact(d, v, -1, 0, 0, fr, sok, gc, got);
            model_apply(d, v, ef);
            if (!got || fr !== ef || !sok) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wrap_frames got %0d bad exp 0", bad);
        end
        checks++;
        if (sample_count !== 8'd0) begin
            errors++; $display("FAIL wrap_count got %0d exp 0", sample_count);
        end
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        exp_under = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL setwins_pre got %b exp 0", underrun);
        end
        xact(TIMEOUT + 1, 16'h0, -1, 1, 0, fr, sok, gc, got);
        model_apply(TIMEOUT + 1, 16'h0, ef);
        checks++;
        if (!got || fr !== ef || !sok) begin
            errors++; $display("FAIL setwins_frame got %h sync_ok %0d exp %h 1", fr, sok, ef);
        end
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL setwins_underrun got %b exp 1", underrun);
        end
    endtask

    task automatic test_reset_mid;
        bit got; int leak;
        got = 1'b0;
        for (int i = 0; i < 3 * DIV && !got; i++) begin
            @(posedge clk); #1;
            if (generate_next_sample) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_req no request seen"); end
        new_sample_ready = 1'b1;
        sample_in        = 16'hFFFF;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        // Now in the 5th SHIFT cycle; assert reset between edges.
        #2;
        reset = 1'b0;
        #1;
        exp_last = '0; exp_count = '0; exp_under = 1'b0;
        checks++;
        if ({generate_next_sample, sdata, sync, underrun, sample_count, last_sample} !== 28'h0) begin
            errors++; $display("FAIL rstmid_async got g=%b d=%b s=%b u=%b c=%0d l=%h exp all 0",
                               generate_next_sample, sdata, sync, underrun, sample_count, last_sample);
        end
        leak = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (sdata || sync || generate_next_sample) leak++;
        end
        #2;
        reset = 1'b1;
        en    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (leak !== 0) begin
            errors++; $display("FAIL rstmid_leak got %0d exp 0", leak);
        end
        checks++;
        if (generate_next_sample !== 1'b1) begin
            errors++; $display("FAIL rstmid_first_req got %b exp 1", generate_next_sample);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period();
        test_timeout();
        test_stray();
        test_random();
        test_en_off();
        test_wrap_setwins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
